uart_tx_serializer: RTL

// - UART transmitter directly downstream of the reconfiguration/dump unit.
// - Consumes its tx_data/new_tx_data byte handshake, returns tx_busy, drives the serial line.
// - Frame: 8N1 by default; optional parity and 2 stop bits.
// - Carries every trace-buffer byte dumped to the host.

---
 rtl/uart_pkg.sv | 23 ++
 rtl/uart_baud_timer.sv | 30 +++
 rtl/uart_tx_serializer.sv | 154 +++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared types and constants for the UART transmit path.
package uart_pkg;

    // Transmitter frame phases.
    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } tx_state_t;

    // Encodings of the PARITY parameter.
    localparam int PARITY_NONE = 0;
    localparam int PARITY_EVEN = 1;
    localparam int PARITY_ODD  = 2;

    // System clocks per serial bit; the remainder is dropped.
    function automatic int clks_per_bit(input int clk_freq, input int baud);
        return clk_freq / baud;
    endfunction

endpackage

// File: rtl/uart_baud_timer.sv
// Bit-period timer: counts 0..CLKS_PER_BIT-1 and flags the last cycle of each bit.
module uart_baud_timer #(
    parameter int CLKS_PER_BIT = 10
) (
    input  logic clk,
    input  logic rst_n,
    input  logic restart,
    output logic bit_done
);

    localparam int TW = $clog2(CLKS_PER_BIT);
    localparam logic [TW-1:0] LAST_COUNT = TW'(CLKS_PER_BIT - 1);

    logic [TW-1:0] timer_reg;

    // Count through one bit period and wrap to zero; restart holds it at zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            timer_reg <= '0;
        end else if (restart || (timer_reg == LAST_COUNT)) begin
            timer_reg <= '0;
        end else begin
            timer_reg <= timer_reg + TW'(1);
        end
    end

    // High during the final cycle of the current bit.
    assign bit_done = (timer_reg == LAST_COUNT);

endmodule

// File: rtl/uart_tx_serializer.sv
// UART transmitter: accepts one byte per request and serialises it as
// start, 8 data bits LSB first, optional parity, then 1 or 2 stop bits.
module uart_tx_serializer #(
    parameter int CLK_FREQ  = 50000000,
    parameter int BAUD_RATE = 115200,
    parameter int PARITY    = 0,
    parameter int STOP_BITS = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] tx_data,
    input  logic       new_tx_data,
    output logic       tx_busy,
    output logic       tx,
    output logic       tx_overrun
);

    import uart_pkg::*;

    // The PARITY parameter shadows the imported state name, so that state is
    // always written as uart_pkg::PARITY below.
    localparam int   CLKS_PER_BIT = clks_per_bit(CLK_FREQ, BAUD_RATE);
    localparam logic PARITY_EN    = (PARITY != PARITY_NONE);
    localparam logic ODD_FLIP     = (PARITY == PARITY_ODD);
    localparam logic LAST_STOP    = (STOP_BITS == 2);

    if (CLKS_PER_BIT < 4) begin : g_cpb_check
        $error("uart_tx_serializer: CLKS_PER_BIT must be at least 4");
    end
    if ((STOP_BITS != 1) && (STOP_BITS != 2)) begin : g_stop_check
        $error("uart_tx_serializer: STOP_BITS must be 1 or 2");
    end
    if ((PARITY < 0) || (PARITY > 2)) begin : g_parity_check
        $error("uart_tx_serializer: PARITY must be 0, 1 or 2");
    end

    tx_state_t  state_reg, state_next;
    logic [7:0] shift_reg, shift_next;
    logic [2:0] bit_idx_reg, bit_idx_next;
    logic       parity_reg, parity_next;
    logic       stop_idx_reg, stop_idx_next;
    logic       tx_reg, tx_next;
    logic       busy_reg, busy_next;
    logic       overrun_reg, overrun_next;
    logic       bit_done;

    // The timer is parked at zero while idle so the start bit gets a full period.
    uart_baud_timer #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_baud_timer (
        .clk     (clk),
        .rst_n   (rst_n),
        .restart (state_reg == IDLE),
        .bit_done(bit_done)
    );

    // State and output registers; reset returns the line high at once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg    <= IDLE;
            shift_reg    <= '0;
            bit_idx_reg  <= '0;
            parity_reg   <= 1'b0;
            stop_idx_reg <= 1'b0;
            tx_reg       <= 1'b1;
            busy_reg     <= 1'b0;
            overrun_reg  <= 1'b0;
        end else begin
            state_reg    <= state_next;
            shift_reg    <= shift_next;
            bit_idx_reg  <= bit_idx_next;
            parity_reg   <= parity_next;
            stop_idx_reg <= stop_idx_next;
            tx_reg       <= tx_next;
            busy_reg     <= busy_next;
            overrun_reg  <= overrun_next;
        end
    end

    // Next-state logic: each transition loads the line value for the coming bit.
    always_comb begin
        state_next    = state_reg;
        shift_next    = shift_reg;
        bit_idx_next  = bit_idx_reg;
        parity_next   = parity_reg;
        stop_idx_next = stop_idx_reg;
        tx_next       = tx_reg;
        busy_next     = busy_reg;
        // Any request seen while busy (including the cycle busy drops) is lost.
        overrun_next  = overrun_reg | (new_tx_data & busy_reg);

        unique case (state_reg)
            IDLE: begin
                if (new_tx_data) begin
                    shift_next    = tx_data;
                    parity_next   = (^tx_data) ^ ODD_FLIP;
                    bit_idx_next  = '0;
                    stop_idx_next = 1'b0;
                    tx_next       = 1'b0;
                    busy_next     = 1'b1;
                    state_next    = START;
                end
            end
            START: begin
                if (bit_done) begin
                    tx_next    = shift_reg[0];
                    shift_next = {1'b0, shift_reg[7:1]};
                    state_next = DATA;
                end
            end
            DATA: begin
                if (bit_done) begin
                    if (bit_idx_reg == 3'd7) begin
                        if (PARITY_EN) begin
                            tx_next    = parity_reg;
                            state_next = uart_pkg::PARITY;
                        end else begin
                            tx_next    = 1'b1;
                            state_next = STOP;
                        end
                    end else begin
                        tx_next      = shift_reg[0];
                        shift_next   = {1'b0, shift_reg[7:1]};
                        bit_idx_next = bit_idx_reg + 3'd1;
                    end
                end
            end
            uart_pkg::PARITY: begin
                if (bit_done) begin
                    tx_next    = 1'b1;
                    state_next = STOP;
                end
            end
            STOP: begin
                if (bit_done) begin
                    if (stop_idx_reg == LAST_STOP) begin
                        busy_next  = 1'b0;
                        state_next = IDLE;
                    end else begin
                        stop_idx_next = 1'b1;
                    end
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign tx         = tx_reg;
    assign tx_busy    = busy_reg;
    assign tx_overrun = overrun_reg;

endmodule
